// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over a req/ack
// handshake and buffers returned words with their PCs in a first-word-fall-through FIFO.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {RUN, DISCARD} state_t;

    state_t         state;
    logic [31:0]    fpc;
    logic [31:0]    hold_addr;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [31:0]    inst_mem [DEPTH];
    logic [31:0]    pc_mem   [DEPTH];

    logic push;
    logic pop;
    logic unused_pc_bits;

    assign unused_pc_bits = &{1'b0, redirect_pc[1:0]};

    // DISCARD keeps the abandoned request alive at its old address until memory acks it
    assign imem_req   = !reset && ((state == DISCARD) || (count < CW'(DEPTH)));
    assign imem_addr  = (state == DISCARD) ? hold_addr : fpc;

    assign inst_valid = (count != '0);
    assign inst_out   = inst_valid ? inst_mem[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : 32'h0;

    assign push = (state == RUN) && imem_req && imem_ack && !redirect;
    assign pop  = inst_valid && inst_ready && !redirect;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= RUN;
            fpc       <= RESET_PC;
            hold_addr <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fpc    <= {redirect_pc[31:2], 2'b00};
            if (state == RUN) begin
                if (imem_req && !imem_ack) begin
                    hold_addr <= fpc;
                    state     <= DISCARD;
                end
            end else if (imem_ack) begin
                state <= RUN;
            end
        end else begin
            if ((state == DISCARD) && imem_ack) begin
                state <= RUN;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                fpc    <= fpc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by count
    always_ff @(posedge CLK) begin
        if (push) begin
            inst_mem[wr_ptr] <= imem_data;
            pc_mem[wr_ptr]   <= fpc;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: a latency-programmable memory responder and a
// scoreboard of expected {pc, word} pairs built from the bench's own address sequence.
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        CLK;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        sb[$];
    ent_t        e;
    int          checks;
    int          failures;
    int          mem_lat;
    int          wait_cnt;
    logic [31:0] exp_addr;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK),
        .reset(reset),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_data(imem_data),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_out(inst_out),
        .inst_pc(inst_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    always #5 CLK = ~CLK;

    // Memory: acks once the current request has waited mem_lat cycles; shares reset
    assign imem_ack  = imem_req && (wait_cnt >= mem_lat);
    assign imem_data = mem_word(imem_addr);

    always @(posedge CLK) begin
        if (reset || !imem_req || imem_ack) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        mem_lat     = 0;
        repeat (2) @(negedge CLK);
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_req got=%b want=0", imem_req);
        end
        checks++;
        if (inst_valid !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_out got v=%b out=%h pc=%h want 0/0/0", inst_valid, inst_out, inst_pc);
        end
        checks++;
        if (imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL reset_addr got=%h want=%h", imem_addr, RESET_PC);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_req got=%b want=1", imem_req);
        end
    endtask

    task automatic test_stream();
        int pops = 0;
        do_reset();
        reset      = 1'b0;
        inst_ready = 1'b1;
        exp_addr   = RESET_PC;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (inst_valid && inst_ready) begin
                checks++;
                pops++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL stream_pop unexpected pc=%h want none", inst_pc);
                end else begin
                    e = sb.pop_front();
                    if (inst_pc !== e.pc || inst_out !== e.inst) begin
                        failures++;
                        $display("FAIL stream_pop got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst_out, e.pc, e.inst);
                    end
                end
            end
            if (imem_req && imem_ack) begin
                checks++;
                if (imem_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL stream_addr got=%h want=%h", imem_addr, exp_addr);
                end
                sb.push_back('{exp_addr, mem_word(exp_addr)});
                exp_addr += 32'd4;
            end
            @(negedge CLK);
        end
        checks++;
        if (pops !== 9) begin
            failures++;
            $display("FAIL stream_rate got pops=%0d want=9", pops);
        end
    endtask

    task automatic test_full();
        int acks = 0;
        do_reset();
        reset    = 1'b0;
        exp_addr = RESET_PC;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (imem_req && imem_ack) begin
                checks++;
                if (imem_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL full_addr got=%h want=%h", imem_addr, exp_addr);
                end
                sb.push_back('{exp_addr, mem_word(exp_addr)});
                exp_addr += 32'd4;
                acks++;
            end
            @(negedge CLK);
        end
        checks++;
        if (acks !== DEPTH || imem_req !== 1'b0 || inst_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_stall got acks=%0d req=%b valid=%b want acks=4 req=0 valid=1", acks, imem_req, inst_valid);
        end
        inst_ready = 1'b1;
        e = sb.pop_front();
        checks++;
        if (inst_pc !== e.pc || inst_out !== e.inst) begin
            failures++;
            $display("FAIL full_pop got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst_out, e.pc, e.inst);
        end
        @(negedge CLK);
        inst_ready = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd16) begin
            failures++;
            $display("FAIL full_resume got req=%b addr=%h want req=1 addr=00000010", imem_req, imem_addr);
        end
        e = sb.pop_front();
        checks++;
        if (inst_pc !== e.pc) begin
            failures++;
            $display("FAIL full_head got pc=%h want=%h", inst_pc, e.pc);
        end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] first_pc = 32'hFFFF_FFFF;
        do_reset();
        reset      = 1'b0;
        mem_lat    = 3;
        inst_ready = 1'b1;
        @(negedge CLK);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge CLK);
        redirect = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL rdw_hold got req=%b addr=%h valid=%b want 1/%h/0", imem_req, imem_addr, inst_valid, RESET_PC);
        end
        @(negedge CLK);
        checks++;
        if (imem_ack !== 1'b1 || imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL rdw_old_ack got ack=%b addr=%h want 1/%h", imem_ack, imem_addr, RESET_PC);
        end
        @(negedge CLK);
        checks++;
        if (imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL rdw_new_addr got addr=%h valid=%b want 00000100/0", imem_addr, inst_valid);
        end
        exp_addr = 32'h100;
        for (int i = 0; i < 16; i++) begin
            if (inst_valid && inst_ready) begin
                checks++;
                if (first_pc === 32'hFFFF_FFFF) first_pc = inst_pc;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rdw_pop unexpected pc=%h want none", inst_pc);
                end else begin
                    e = sb.pop_front();
                    if (inst_pc !== e.pc || inst_out !== e.inst) begin
                        failures++;
                        $display("FAIL rdw_pop got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst_out, e.pc, e.inst);
                    end
                end
            end
            if (imem_req && imem_ack) begin
                checks++;
                if (imem_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL rdw_addr got=%h want=%h", imem_addr, exp_addr);
                end
                sb.push_back('{exp_addr, mem_word(exp_addr)});
                exp_addr += 32'd4;
            end
            @(negedge CLK);
        end
        checks++;
        if (first_pc !== 32'h100) begin
            failures++;
            $display("FAIL rdw_first_pc got=%h want=00000100", first_pc);
        end
    endtask

    task automatic test_redirect_collide();
        do_reset();
        reset      = 1'b0;
        inst_ready = 1'b1;
        exp_addr   = RESET_PC;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (imem_req && imem_ack) begin
                sb.push_back('{exp_addr, mem_word(exp_addr)});
                exp_addr += 32'd4;
            end
            @(negedge CLK);
        end
        checks++;
        if (inst_valid !== 1'b1 || imem_req !== 1'b1 || imem_ack !== 1'b1) begin
            failures++;
            $display("FAIL rdc_setup got valid=%b req=%b ack=%b want 1/1/1", inst_valid, imem_req, imem_ack);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        @(negedge CLK);
        redirect = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (inst_valid !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 32'h0) begin
            failures++;
            $display("FAIL rdc_flush got valid=%b out=%h pc=%h want 0/0/0", inst_valid, inst_out, inst_pc);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL rdc_addr got req=%b addr=%h want 1/00000200", imem_req, imem_addr);
        end
        exp_addr = 32'h200;
        for (int i = 0; i < 5; i++) begin
            if (inst_valid && inst_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rdc_pop unexpected pc=%h want none", inst_pc);
                end else begin
                    e = sb.pop_front();
                    if (inst_pc !== e.pc || inst_out !== e.inst) begin
                        failures++;
                        $display("FAIL rdc_pop got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst_out, e.pc, e.inst);
                    end
                end
            end
            if (imem_req && imem_ack) begin
                sb.push_back('{exp_addr, mem_word(exp_addr)});
                exp_addr += 32'd4;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_wrap();
        logic seen_top  = 1'b0;
        logic seen_zero = 1'b0;
        do_reset();
        reset       = 1'b0;
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        @(negedge CLK);
        redirect = 1'b0;
        sb.delete();
        exp_addr = 32'hFFFF_FFF8;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (inst_valid && inst_ready) begin
                checks++;
                if (inst_pc === 32'hFFFF_FFFC) seen_top = 1'b1;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL wrap_pop unexpected pc=%h want none", inst_pc);
                end else begin
                    e = sb.pop_front();
                    if (inst_pc !== e.pc || inst_out !== e.inst) begin
                        failures++;
                        $display("FAIL wrap_pop got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst_out, e.pc, e.inst);
                    end
                end
            end
            if (imem_req && imem_ack) begin
                checks++;
                if (imem_addr === 32'h0) seen_zero = 1'b1;
                if (imem_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL wrap_addr got=%h want=%h", imem_addr, exp_addr);
                end
                sb.push_back('{exp_addr, mem_word(exp_addr)});
                exp_addr += 32'd4;
            end
            @(negedge CLK);
        end
        checks++;
        if (seen_top !== 1'b1 || seen_zero !== 1'b1) begin
            failures++;
            $display("FAIL wrap_seen got top=%b zero=%b want 1/1", seen_top, seen_zero);
        end
    endtask

    task automatic test_reset_midwait();
        int acks = 0;
        logic got_ack = 1'b0;
        do_reset();
        reset    = 1'b0;
        mem_lat  = 2;
        exp_addr = RESET_PC;
        #1;
        for (int i = 0; i < 30 && acks < 2; i++) begin
            if (imem_req && imem_ack) begin
                checks++;
                if (imem_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL rmw_addr got=%h want=%h", imem_addr, exp_addr);
                end
                exp_addr += 32'd4;
                acks++;
            end
            @(negedge CLK);
        end
        checks++;
        if (acks !== 2 || inst_valid !== 1'b1 || imem_req !== 1'b1 || imem_ack !== 1'b0) begin
            failures++;
            $display("FAIL rmw_setup got acks=%0d valid=%b req=%b ack=%b want 2/1/1/0", acks, inst_valid, imem_req, imem_ack);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL rmw_req_in_reset got=%b want=0", imem_req);
        end
        @(negedge CLK);
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL rmw_req_held got=%b want=0", imem_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || imem_addr !== RESET_PC || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL rmw_release got valid=%b addr=%h req=%b want 0/%h/1", inst_valid, imem_addr, imem_req, RESET_PC);
        end
        for (int i = 0; i < 10 && !got_ack; i++) begin
            if (imem_req && imem_ack) begin
                got_ack = 1'b1;
                checks++;
                if (imem_addr !== RESET_PC) begin
                    failures++;
                    $display("FAIL rmw_first_addr got=%h want=%h", imem_addr, RESET_PC);
                end
            end else begin
                @(negedge CLK);
            end
        end
        checks++;
        if (got_ack !== 1'b1) begin
            failures++;
            $display("FAIL rmw_timeout got no ack within 10 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        CLK         = 1'b0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        mem_lat     = 0;
        checks      = 0;
        failures    = 0;
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_collide();
        test_wrap();
        test_reset_midwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
